// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, master FSM states and protection default.
package axi_lite_pkg;
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;
   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } mst_state_t;
   localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axi_lite_to_cnt.sv
// axi_lite_to_cnt: per-state wait counter; expires on the last allowed wait cycle.
module axi_lite_to_cnt #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TO_W           = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   logic [TO_W-1:0] r_cnt;
   always_ff @(posedge i_clk)
      if (i_rst || i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 1'b1;
   // A zero budget disables expiry entirely.
   assign o_expire = (TIMEOUT_CYCLES != 0) && i_en && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd: single-outstanding AXI4-Lite master behind a valid/ready
// command port, returning one response per command with optional timeout abort.
module axi_lite_master_cmd
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int TO_W           = 16
) (
   input  logic                i_axi_aclk,
   input  logic                i_axi_areset,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic                i_cmd_write,
   input  logic [ADDR_W-1:0]   i_cmd_addr,
   input  logic [DATA_W-1:0]   i_cmd_wdata,
   input  logic [DATA_W/8-1:0] i_cmd_wstrb,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic                o_rsp_write,
   output logic [DATA_W-1:0]   o_rsp_rdata,
   output logic [1:0]          o_rsp_resp,
   output logic                o_rsp_timeout,
   output logic                o_axi_awvalid,
   input  logic                i_axi_awready,
   output logic [ADDR_W-1:0]   o_axi_awaddr,
   output logic [2:0]          o_axi_awprot,
   output logic                o_axi_wvalid,
   input  logic                i_axi_wready,
   output logic [DATA_W-1:0]   o_axi_wdata,
   output logic [DATA_W/8-1:0] o_axi_wstrb,
   input  logic                i_axi_bvalid,
   output logic                o_axi_bready,
   input  logic [1:0]          i_axi_bresp,
   output logic                o_axi_arvalid,
   input  logic                i_axi_arready,
   output logic [ADDR_W-1:0]   o_axi_araddr,
   output logic [2:0]          o_axi_arprot,
   input  logic                i_axi_rvalid,
   output logic                o_axi_rready,
   input  logic [DATA_W-1:0]   i_axi_rdata,
   input  logic [1:0]          i_axi_rresp
);
   mst_state_t          r_state, w_state_next;
   logic                r_write, r_aw_done, r_w_done, r_timeout;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic [1:0]          r_resp;
   logic                w_accept, w_aw_hs, w_w_hs, w_wait, w_expire, w_abort;

   assign o_cmd_ready   = (r_state == IDLE) && !i_axi_areset;
   assign w_accept      = i_cmd_valid && o_cmd_ready;
   assign o_axi_awvalid = (r_state == WR_REQ) && !r_aw_done;
   assign o_axi_wvalid  = (r_state == WR_REQ) && !r_w_done;
   assign o_axi_bready  = r_state == WR_RESP;
   assign o_axi_arvalid = r_state == RD_REQ;
   assign o_axi_rready  = r_state == RD_RESP;
   assign o_rsp_valid   = r_state == RSP;
   assign w_aw_hs       = o_axi_awvalid && i_axi_awready;
   assign w_w_hs        = o_axi_wvalid && i_axi_wready;
   assign w_wait        = r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
   assign o_axi_awaddr  = r_addr;
   assign o_axi_araddr  = r_addr;
   assign o_axi_wdata   = r_wdata;
   assign o_axi_wstrb   = r_wstrb;
   assign o_axi_awprot  = PROT_DEFAULT;
   assign o_axi_arprot  = PROT_DEFAULT;
   assign o_rsp_write   = r_write;
   assign o_rsp_rdata   = r_rdata;
   assign o_rsp_resp    = r_resp;
   assign o_rsp_timeout = r_timeout;

   // Counter restarts on every state change, giving each wait state its own budget.
   axi_lite_to_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TO_W          (TO_W)
   ) u_to_cnt (
      .i_clk   (i_axi_aclk),
      .i_rst   (i_axi_areset),
      .i_clr   (r_state != w_state_next),
      .i_en    (w_wait),
      .o_expire(w_expire)
   );

   always_ff @(posedge i_axi_aclk)
      if (i_axi_areset) r_state <= IDLE;
      else r_state <= w_state_next;

   // A handshake completing in the expiry cycle takes priority over the abort.
   always_comb begin
      w_state_next = r_state;
      w_abort      = 1'b0;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = i_cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_next = WR_RESP;
                  else w_abort = w_expire;
         WR_RESP: if (i_axi_bvalid) w_state_next = RSP;
                  else w_abort = w_expire;
         RD_REQ:  if (i_axi_arready) w_state_next = RD_RESP;
                  else w_abort = w_expire;
         RD_RESP: if (i_axi_rvalid) w_state_next = RSP;
                  else w_abort = w_expire;
         RSP:     if (i_rsp_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (w_abort) w_state_next = RSP;
   end

   always_ff @(posedge i_axi_aclk)
      if (i_axi_areset) begin
         r_write   <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_timeout <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_resp    <= '0;
      end else begin
         if (w_accept) begin
            r_write   <= i_cmd_write;
            r_addr    <= i_cmd_addr;
            r_wdata   <= i_cmd_wdata;
            r_wstrb   <= i_cmd_wstrb;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end
         if (r_state == WR_REQ) begin
            r_aw_done <= r_aw_done || w_aw_hs;
            r_w_done  <= r_w_done || w_w_hs;
         end
         if (r_state == WR_RESP && i_axi_bvalid) begin
            r_resp    <= i_axi_bresp;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
         end
         if (r_state == RD_RESP && i_axi_rvalid) begin
            r_resp    <= i_axi_rresp;
            r_rdata   <= i_axi_rdata;
            r_timeout <= 1'b0;
         end
         if (w_abort) begin
            r_resp    <= SLVERR;
            r_rdata   <= '0;
            r_timeout <= 1'b1;
         end
      end
endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb_axi_lite_master_cmd: directed table, reset/64-bit sequences and random
// transactions checked against a delay-based response/latency model.
module tb_axi_lite_master_cmd;
   localparam int TO = 8;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic [1:0]  resp;
      int          bp;
      int          exp_lat;
      logic [1:0]  exp_resp;
      bit          exp_to;
      logic [31:0] exp_rdata;
   } txn_t;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0, errors = 0;

   logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [11:0] cmd_addr, awaddr, araddr;
   logic [31:0] cmd_wdata, rsp_rdata, wdata, rdata;
   logic [3:0]  cmd_wstrb, wstrb;
   logic [1:0]  rsp_resp, bresp, rresp;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;

   axi_lite_master_cmd #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
      .i_axi_aclk(clk), .i_axi_areset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
      .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
      .o_axi_awvalid(awvalid), .i_axi_awready(awready), .o_axi_awaddr(awaddr), .o_axi_awprot(awprot),
      .o_axi_wvalid(wvalid), .i_axi_wready(wready), .o_axi_wdata(wdata), .o_axi_wstrb(wstrb),
      .i_axi_bvalid(bvalid), .o_axi_bready(bready), .i_axi_bresp(bresp),
      .o_axi_arvalid(arvalid), .i_axi_arready(arready), .o_axi_araddr(araddr), .o_axi_arprot(arprot),
      .i_axi_rvalid(rvalid), .o_axi_rready(rready), .i_axi_rdata(rdata), .i_axi_rresp(rresp)
   );

   logic        c6_valid, c6_ready, c6_write, r6_valid, r6_ready, r6_write, r6_timeout;
   logic [11:0] c6_addr, aw6_addr, ar6_addr;
   logic [63:0] c6_wdata, r6_rdata, w6_data;
   logic [7:0]  c6_wstrb, w6_strb;
   logic [1:0]  r6_resp;
   logic [2:0]  aw6_prot, ar6_prot;
   logic        aw6_valid, w6_valid, b6_ready, ar6_valid, r6_rready;

   // Always-ready slave; its constant bvalid/rvalid are spurious outside the wait states.
   axi_lite_master_cmd #(.ADDR_W(12), .DATA_W(64), .TIMEOUT_CYCLES(0), .TO_W(16)) dut64 (
      .i_axi_aclk(clk), .i_axi_areset(rst),
      .i_cmd_valid(c6_valid), .o_cmd_ready(c6_ready), .i_cmd_write(c6_write),
      .i_cmd_addr(c6_addr), .i_cmd_wdata(c6_wdata), .i_cmd_wstrb(c6_wstrb),
      .o_rsp_valid(r6_valid), .i_rsp_ready(r6_ready), .o_rsp_write(r6_write),
      .o_rsp_rdata(r6_rdata), .o_rsp_resp(r6_resp), .o_rsp_timeout(r6_timeout),
      .o_axi_awvalid(aw6_valid), .i_axi_awready(1'b1), .o_axi_awaddr(aw6_addr), .o_axi_awprot(aw6_prot),
      .o_axi_wvalid(w6_valid), .i_axi_wready(1'b1), .o_axi_wdata(w6_data), .o_axi_wstrb(w6_strb),
      .i_axi_bvalid(1'b1), .o_axi_bready(b6_ready), .i_axi_bresp(2'b00),
      .o_axi_arvalid(ar6_valid), .i_axi_arready(1'b1), .o_axi_araddr(ar6_addr), .o_axi_arprot(ar6_prot),
      .i_axi_rvalid(1'b1), .o_axi_rready(r6_rready), .i_axi_rdata(64'h0123456789ABCDEF), .i_axi_rresp(2'b00)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic txn_t mk(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int aw_d, w_d, b_d, ar_d, r_d,
                               input logic [1:0] resp, input int bp, input int lat,
                               input logic [1:0] eresp, input bit eto, input logic [31:0] erdata);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data; t.strb = strb;
      t.aw_d = aw_d; t.w_d = w_d; t.b_d = b_d; t.ar_d = ar_d; t.r_d = r_d;
      t.resp = resp; t.bp = bp; t.exp_lat = lat; t.exp_resp = eresp; t.exp_to = eto; t.exp_rdata = erdata;
      return t;
   endfunction

   // Each wait state allows TO cycles; ready/valid arriving on cycle index d finishes it in d+1.
   function automatic txn_t predict(input txn_t t);
      int  da, db;
      bit  req_to, rsp_to;
      da = t.wr ? (t.aw_d > t.w_d ? t.aw_d : t.w_d) : t.ar_d;
      db = t.wr ? t.b_d : t.r_d;
      req_to = da >= TO;
      rsp_to = !req_to && db >= TO;
      t.exp_lat   = req_to ? 1 + TO : 1 + (da + 1) + (rsp_to ? TO : db + 1);
      t.exp_to    = req_to || rsp_to;
      t.exp_resp  = t.exp_to ? 2'b10 : t.resp;
      t.exp_rdata = (t.exp_to || t.wr) ? 32'h0 : t.data;
      return t;
   endfunction

   txn_t cur;
   int aw_c, w_c, ar_c, b_c, r_c, b_hs;

   always @(negedge clk) begin
      awready = awvalid && aw_c == cur.aw_d;
      if (awvalid) aw_c++;
      wready = wvalid && w_c == cur.w_d;
      if (wvalid) w_c++;
      arready = arvalid && ar_c == cur.ar_d;
      if (arvalid) ar_c++;
      bvalid = bready && b_c == cur.b_d;
      if (bready) b_c++;
      if (bvalid) b_hs++;
      rvalid = rready && r_c == cur.r_d;
      if (rready) r_c++;
      bresp = cur.resp;
      rresp = cur.resp;
      rdata = cur.data;
      if (awvalid) begin
         chk("awaddr", awaddr, cur.addr);
         chk("awprot", awprot, 0);
      end
      if (wvalid) begin
         chk("wdata", wdata, cur.data);
         chk("wstrb", wstrb, cur.strb);
      end
      if (arvalid) begin
         chk("araddr", araddr, cur.addr);
         chk("arprot", arprot, 0);
      end
   end

   task automatic issue(input txn_t t, output int acc);
      int n;
      @(negedge clk);
      cur = t;
      aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; b_hs = 0;
      cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr; cmd_wdata = t.data; cmd_wstrb = t.strb;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready", cmd_ready, 1);
      acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = 12'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
   endtask

   task automatic run_txn(input txn_t t);
      int n, acc;
      issue(t, acc);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(cyc - acc), 64'(t.exp_lat));
      for (int i = 0; i <= t.bp; i++) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_write", rsp_write, t.wr);
         chk("rsp_resp", rsp_resp, t.exp_resp);
         chk("rsp_timeout", rsp_timeout, t.exp_to);
         chk("rsp_rdata", rsp_rdata, t.exp_rdata);
         chk("quiet_bus", {cmd_ready, awvalid, wvalid, bready, arvalid, rready}, 0);
         if (i < t.bp) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("idle_ready", cmd_ready, 1);
      if (t.wr && !t.exp_to) chk("b_count", b_hs, 1);
   endtask

   txn_t tbl[10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int acc, n;
      txn_t t;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
      c6_valid = 0; c6_write = 0; c6_addr = 0; c6_wdata = 0; c6_wstrb = 0; r6_ready = 0;
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0] = mk(1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 3, 2'b00, 0, 32'h0);
      tbl[1] = mk(1, 12'h014, 32'hCAFEF00D, 4'h3, 3, 0, 1, 0, 0, 2'b00, 0, 7, 2'b00, 0, 32'h0);
      tbl[2] = mk(0, 12'h020, 32'h12345678, 4'h0, 0, 0, 0, 2, 0, 2'b10, 0, 5, 2'b10, 0, 32'h12345678);
      tbl[3] = mk(0, 12'h030, 32'h00000099, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 0, 9, 2'b10, 1, 32'h0);
      tbl[4] = mk(0, 12'h040, 32'hAABBCCDD, 4'h0, 0, 0, 0, 0, 0, 2'b00, 5, 3, 2'b00, 0, 32'hAABBCCDD);
      tbl[5] = mk(1, 12'h044, 32'h01020304, 4'hC, 0, 0, 7, 0, 0, 2'b11, 0, 10, 2'b11, 0, 32'h0);
      tbl[6] = mk(1, 12'h048, 32'h00000055, 4'h1, 0, 0, 8, 0, 0, 2'b00, 0, 10, 2'b10, 1, 32'h0);
      tbl[7] = mk(0, 12'h04C, 32'h00000005, 4'h0, 0, 0, 0, 0, 7, 2'b01, 0, 10, 2'b01, 0, 32'h5);
      tbl[8] = mk(1, 12'h050, 32'h0BADF00D, 4'hF, 0, 8, 0, 0, 0, 2'b00, 1, 9, 2'b10, 1, 32'h0);
      tbl[9] = mk(1, 12'h054, 32'h00000077, 4'hF, 2, 7, 0, 0, 0, 2'b00, 0, 10, 2'b00, 0, 32'h0);
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_bus", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
      rst = 1'b0;
      #1 chk("post_reset_cmd_ready", cmd_ready, 1);
      foreach (tbl[i]) run_txn(tbl[i]);

      // Reset while waiting for B: everything drops with no drain.
      t = mk(1, 12'h060, 32'h13572468, 4'hF, 0, 0, 1000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 32'h0);
      issue(t, acc);
      n = 0;
      while (!bready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("in_wr_resp", bready, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_reset_bus", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
      rst = 1'b0;
      #1 chk("after_mid_reset_cmd_ready", cmd_ready, 1);
      run_txn(tbl[0]);

      for (int i = 0; i < 24; i++) begin
         t = mk($urandom_range(0, 1), 12'($urandom), $urandom, 4'($urandom),
                ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3),
                2'($urandom), $urandom_range(0, 3), 0, 0, 0, 0);
         run_txn(predict(t));
      end

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         c6_valid = 1'b1; c6_write = (k == 0); c6_addr = 12'h100 + 12'(k * 8);
         c6_wdata = 64'h1122334455667788; c6_wstrb = 8'hF0;
         n = 0;
         while (!c6_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("w64_cmd_ready", c6_ready, 1);
         acc = cyc;
         @(negedge clk);
         c6_valid = 1'b0;
         if (k == 0) begin
            chk("w64_wvalid", w6_valid, 1);
            chk("w64_wstrb", w6_strb, 8'hF0);
            chk("w64_wdata", w6_data, 64'h1122334455667788);
            chk("w64_awaddr", aw6_addr, 12'h100);
         end else chk("r64_araddr", ar6_addr, 12'h108);
         n = 0;
         while (!r6_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("x64_latency", 64'(cyc - acc), 64'd3);
         chk("x64_write", r6_write, k == 0);
         chk("x64_resp", {r6_timeout, r6_resp}, 0);
         chk("x64_rdata", r6_rdata, (k == 0) ? 64'h0 : 64'h0123456789ABCDEF);
         r6_ready = 1'b1;
         @(negedge clk);
         r6_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
Parametrised AXI4-Lite master driven by a valid/ready command port. It returns one response per command on a valid/ready response port.
Generalises the fixed 12/32-bit write/read FSM master:
- configurable address and data widths, caller-supplied WSTRB;
- AW and W issued concurrently, with independent handshakes;
- B-channel and RRESP capture;
- optional per-transaction timeout.
Sits between firmware/test-sequencer logic and any AXI-Lite slave register block in the fsic fabric. One transaction is outstanding at a time.

Parameters:
ADDR_W, 12, AXI address width (bits)
DATA_W, 32, AXI data width; must be 32 or 64
TIMEOUT_CYCLES, 0, cycles to wait in any AXI wait state before abort; 0 disables timeout
TO_W, 16, timeout counter width; TIMEOUT_CYCLES < 2**TO_W

Ports:
axi_aclk  in  1  clock
axi_areset  in  1  reset; synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by timeout
axi_awvalid/axi_awready  out/in  1  write-address handshake
axi_awaddr  out  ADDR_W
axi_awprot  out  3  constant 3'b000
axi_wvalid/axi_wready  out/in  1  write-data handshake
axi_wdata  out  DATA_W
axi_wstrb  out  DATA_W/8
axi_bvalid/axi_bready  in/out  1  write-response handshake
axi_bresp  in  2
axi_arvalid/axi_arready  out/in  1  read-address handshake
axi_araddr  out  ADDR_W
axi_arprot  out  3  constant 3'b000
axi_rvalid/axi_rready  in/out  1  read-data handshake
axi_rdata  in  DATA_W
axi_rresp  in  2

Behaviour:
Reset (axi_areset high at posedge), applies mid-transaction too, no drain:
- state is IDLE;
- all AXI valid/ready outputs are 0, cmd_ready = 0, rsp_valid = 0;
- address, data and strb registers are 0, counter is 0.
- The first cycle after reset deasserts has cmd_ready = 1.

States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.

IDLE:
- cmd_ready = 1 (combinational, IDLE only).
- On accept, register addr/wdata/wstrb/write.
- Write goes to WR_REQ: axi_awvalid and axi_wvalid both 1 on the next cycle.
- Read goes to RD_REQ: axi_arvalid = 1 on the next cycle.

WR_REQ:
- Flags aw_done and w_done are set on their respective handshakes.
- Each valid drops the cycle after its own handshake.
- The other valid stays high, with its payload stable.
- When both flags are set (same cycle allowed), go to WR_RESP.

WR_RESP:
- axi_bready = 1.
- On axi_bvalid, latch bresp, rdata = 0, go to RSP.

RD_REQ:
- On axi_arready, go to RD_RESP.

RD_RESP:
- axi_rready = 1.
- On axi_rvalid, latch rdata and rresp, go to RSP.

RSP:
- rsp_valid = 1; rsp_* outputs come from registers and are stable until rsp_ready.
- On handshake, go to IDLE.
- No new command is accepted in the same cycle, so the command-to-command minimum is 4 cycles with zero-wait slaves.

Minimum latency:
- write: accept at cycle N; AW/W valid at N+1; B handshake at N+2; rsp_valid at N+3.
- read: same cycle positions.

Timeout:
- Counter clears on entry to WR_REQ, WR_RESP, RD_REQ or RD_RESP.
- Increments every cycle spent in those states.
- When the counter reaches TIMEOUT_CYCLES, all AXI valids/readys drop, rsp_resp = 2'b10, rsp_timeout = 1, rdata = 0, and state goes to RSP.
- A handshake in the same cycle as expiry wins: normal completion, no timeout.
- Abort is a debug recovery only; the slave state is undefined afterwards.

Response codes:
- Non-OKAY responses (2'b10, 2'b11) are passed through unchanged with rsp_timeout = 0.

Ready signals and unused fields:
- axi_bready and axi_rready are asserted only in their own states.
- Spurious axi_bvalid/axi_rvalid in other states is ignored.
- axi_awaddr, axi_wdata and axi_araddr are driven from registers; their value is don't-care when the corresponding valid is low.

Decomposition:
- Package axi_lite_pkg:
  - resp_t enum (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3);
  - mst_state_t enum;
  - PROT_DEFAULT constant = 3'b000.
- Sub-module axi_lite_to_cnt: loadable timeout counter with enable and expire output, bypassed (expire tied 0) when TIMEOUT_CYCLES == 0.
- Everything else lives in one module.

Test Plan:
1. Write addr 12'h010, data 32'hDEADBEEF, strb 4'hF; awready/wready/bvalid immediately; bresp 0 -> awaddr = 12'h010 and wdata = DEADBEEF on one cycle; rsp_valid 3 cycles after accept; rsp_resp 0; rsp_write 1.
2. Split write: wready 3 cycles before awready; strb 4'h3 -> wvalid drops after its handshake; awvalid held with stable addr until accepted; exactly one B consumed; axi_wstrb = 4'h3.
3. Read addr 12'h020; arready delayed 2 cycles; rvalid with rdata 32'h12345678, rresp 2 -> rsp_rdata = 12345678, rsp_resp = 2, rsp_timeout = 0.
4. TIMEOUT_CYCLES = 8; slave never asserts arready -> arvalid drops after 8 cycles; rsp_timeout = 1; rsp_resp = 2; next command accepted normally.
5. Back-pressure: rsp_ready held low 5 cycles -> rsp_* stable; cmd_ready stays 0; no AXI activity.
6. Reset asserted while in WR_RESP -> next cycle all valids/readys = 0, rsp_valid = 0; after release cmd_ready = 1; DATA_W = 64 regression with strb 8'hF0.
